// File: rtl/lly_seq_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding,
// idle line level and the length/repeat clamp helper.
package lly_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic IDLE_LVL_DEF = 1'b1;

  // Zero becomes one and anything above max_val saturates to max_val.
  function automatic int unsigned clamp_cnt(input int unsigned val, input int unsigned max_val);
    if (val == 0)
      return 1;
    else if (val > max_val)
      return max_val;
    else
      return val;
  endfunction

endpackage

// File: rtl/lly_seq_tx_if.sv
// Control/status bundle of the serial pattern transmitter; the master side
// issues requests and the slave side (the transmitter) returns the stream.
interface lly_seq_tx_if #(
  parameter int W     = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
);

  logic             start;
  logic             abort;
  logic [W-1:0]     pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic             dout;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] frame_idx;

  modport master (
    output start, abort, pattern, len, rep,
    input  dout, bit_valid, busy, done, frame_idx
  );

  modport slave (
    input  start, abort, pattern, len, rep,
    output dout, bit_valid, busy, done, frame_idx
  );

endinterface

// File: rtl/lly_tx_shreg.sv
// Loadable MSB-first shift register: the pattern is left-aligned so bit len-1
// sits at the top, and a down-counter flags the last bit of the frame.
module lly_tx_shreg #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             advance,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len_c,
  output logic             load_bit,
  output logic             reload_bit,
  output logic             next_bit,
  output logic             last
);

  logic [W-1:0]     aln_q;
  logic [W-1:0]     sh_q;
  logic [W-1:0]     aln_in;
  logic [W-1:0]     sh_adv;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;

  assign aln_in     = pattern << (LEN_W'(W) - len_c);
  assign sh_adv     = sh_q << 1;
  assign load_bit   = aln_in[W-1];
  assign reload_bit = aln_q[W-1];
  assign next_bit   = sh_adv[W-1];
  assign last       = (cnt_q == '0);

  // The aligned copy is kept so repeated frames restart from the same bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      aln_q <= '0;
      sh_q  <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      aln_q <= aln_in;
      sh_q  <= aln_in;
      len_q <= len_c;
      cnt_q <= len_c - LEN_W'(1);
    end else if (reload) begin
      sh_q  <= aln_q;
      cnt_q <= len_q - LEN_W'(1);
    end else if (advance && !last) begin
      sh_q  <= sh_adv;
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

endmodule

// File: rtl/lly_seq_tx.sv
// Serial pattern transmitter: sends a clamped-length pattern MSB-first,
// optionally repeated with idle gaps, with busy/bit_valid/done status.
module lly_seq_tx
  import lly_seq_pkg::*;
#(
  parameter int   W        = 8,
  parameter int   LEN_W    = 4,
  parameter int   REP_W    = 4,
  parameter int   GAP_CYC  = 1,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  lly_seq_tx_if.slave   bus
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_t           state_q, state_n;
  logic             dout_q, dout_n;
  logic             bv_q, bv_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [REP_W-1:0] fidx_q, fidx_n;
  logic [REP_W-1:0] rep_q, rep_n;
  logic [GAP_W-1:0] gap_q, gap_n;

  logic             sh_load, sh_reload, sh_adv;
  logic             load_bit, reload_bit, next_bit, last;
  logic [LEN_W-1:0] len_c;
  logic [REP_W-1:0] rep_c;
  logic [REP_W:0]   fidx_inc;
  logic             more_frames;

  assign len_c       = LEN_W'(clamp_cnt(32'(bus.len), int'(W)));
  assign rep_c       = REP_W'(clamp_cnt(32'(bus.rep), (2 ** REP_W) - 1));
  assign fidx_inc    = {1'b0, fidx_q} + (REP_W+1)'(1);
  assign more_frames = fidx_inc < {1'b0, rep_q};

  lly_tx_shreg #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk        (Clk),
    .rst        (Reset),
    .load       (sh_load),
    .reload     (sh_reload),
    .advance    (sh_adv),
    .pattern    (bus.pattern),
    .len_c      (len_c),
    .load_bit   (load_bit),
    .reload_bit (reload_bit),
    .next_bit   (next_bit),
    .last       (last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      dout_q  <= IDLE_LVL;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fidx_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_n;
      dout_q  <= dout_n;
      bv_q    <= bv_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      fidx_q  <= fidx_n;
      rep_q   <= rep_n;
      gap_q   <= gap_n;
    end
  end

  // Every output is computed one edge ahead so the ports come straight from flops.
  always_comb begin
    state_n   = state_q;
    dout_n    = IDLE_LVL;
    bv_n      = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    fidx_n    = fidx_q;
    rep_n     = rep_q;
    gap_n     = gap_q;
    sh_load   = 1'b0;
    sh_reload = 1'b0;
    sh_adv    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          sh_load = 1'b1;
          rep_n   = rep_c;
          fidx_n  = '0;
          dout_n  = load_bit;
          bv_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else begin
          busy_n = 1'b1;
          if (!last) begin
            sh_adv = 1'b1;
            dout_n = next_bit;
            bv_n   = 1'b1;
          end else begin
            fidx_n = fidx_inc[REP_W-1:0];
            if (!more_frames) begin
              done_n  = 1'b1;
              state_n = S_DONE;
            end else if (GAP_CYC > 0) begin
              gap_n   = GAP_INIT;
              state_n = S_GAP;
            end else begin
              sh_reload = 1'b1;
              dout_n    = reload_bit;
              bv_n      = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_n = S_IDLE;
        end else begin
          busy_n = 1'b1;
          if (gap_q == '0) begin
            sh_reload = 1'b1;
            dout_n    = reload_bit;
            bv_n      = 1'b1;
            state_n   = S_SHIFT;
          end else begin
            gap_n = gap_q - GAP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.bit_valid = bv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_idx = fidx_q;

endmodule

// File: tb/tb_lly_seq_tx.sv
// Bench for lly_seq_tx: a gapped (GAP_CYC=1) and a back-to-back (GAP_CYC=0)
// instance share stimulus and are compared every cycle to a frame-list model.
module tb_lly_seq_tx;

  logic clk;
  logic rst;
  int   assert_count = 0;
  int   fail_count   = 0;
  bit   check_en     = 1'b0;

  // Expected per-cycle outputs, packed as {frame_idx, done, busy, bit_valid, dout}.
  logic [7:0] cur_e [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int         det_count = 0;
  logic [3:0] win = 4'hF;

  logic       d_a [20];
  logic       v_a [20];
  logic       b_a [20];
  logic       n_a [20];
  logic [3:0] f_a [20];
  logic       d_b [20];
  logic       n_b [20];

  lly_seq_tx_if #(.W(8), .LEN_W(4), .REP_W(4)) bus_a ();
  lly_seq_tx_if #(.W(8), .LEN_W(4), .REP_W(4)) bus_b ();

  lly_seq_tx #(.W(8), .LEN_W(4), .REP_W(4), .GAP_CYC(1), .IDLE_LVL(1'b1)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_a)
  );

  lly_seq_tx #(.W(8), .LEN_W(4), .REP_W(4), .GAP_CYC(0), .IDLE_LVL(1'b1)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_e(input int m, input logic [7:0] v);
    if (m == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Lay out the whole transmission: frames of bits, gaps between frames, then done.
  task automatic build_tx(input int m, input logic [7:0] pat, input logic [3:0] len_in, input logic [3:0] rep_in);
    int l;
    int r;
    int g;
    l = (len_in == 0) ? 1 : ((len_in > 8) ? 8 : int'(len_in));
    r = (rep_in == 0) ? 1 : int'(rep_in);
    g = (m == 0) ? 1 : 0;
    for (int f = 0; f < r; f++) begin
      for (int i = l - 1; i >= 0; i--)
        push_e(m, {4'(f), 1'b0, 1'b1, 1'b1, pat[i]});
      if (f < r - 1)
        for (int j = 0; j < g; j++)
          push_e(m, {4'(f + 1), 1'b0, 1'b1, 1'b0, 1'b1});
    end
    push_e(m, {4'(r), 1'b1, 1'b1, 1'b0, 1'b1});
  endtask

  task automatic model_step(input int m);
    logic [7:0] c;
    int         qs;
    c  = cur_e[m];
    qs = (m == 0) ? q0.size() : q1.size();
    if (rst) begin
      q0.delete(); q1.delete();
      cur_e[m] = 8'h01;
    end else if (c[2] && !c[3] && bus_a.abort) begin
      if (m == 0) q0.delete(); else q1.delete();
      cur_e[m] = {c[7:4], 4'b0001};
    end else if (qs > 0) begin
      cur_e[m] = (m == 0) ? q0.pop_front() : q1.pop_front();
    end else if (c[2]) begin
      cur_e[m] = {c[7:4], 4'b0001};
    end else if (!bus_a.abort && bus_a.start) begin
      build_tx(m, bus_a.pattern, bus_a.len, bus_a.rep);
      cur_e[m] = (m == 0) ? q0.pop_front() : q1.pop_front();
    end
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) model_step(m);
    win = {win[2:0], bus_a.dout};
    if (win == 4'b0101) det_count++;
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_a", {24'd0, bus_a.frame_idx, bus_a.done, bus_a.busy, bus_a.bit_valid, bus_a.dout}, {24'd0, cur_e[0]});
      checkOutput("model_b", {24'd0, bus_b.frame_idx, bus_b.done, bus_b.busy, bus_b.bit_valid, bus_b.dout}, {24'd0, cur_e[1]});
    end
  end

  task automatic set_in(input logic s, input logic a, input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    bus_a.start = s; bus_a.abort = a; bus_a.pattern = p; bus_a.len = l; bus_a.rep = r;
    bus_b.start = s; bus_b.abort = a; bus_b.pattern = p; bus_b.len = l; bus_b.rep = r;
  endtask

  // Pulses start for exactly one edge (edge k); returns early in cycle k+1.
  task automatic applyStimulus(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, p, l, r);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, p, l, r);
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_a[i] = bus_a.dout;  v_a[i] = bus_a.bit_valid; b_a[i] = bus_a.busy;
      n_a[i] = bus_a.done;  f_a[i] = bus_a.frame_idx;
      d_b[i] = bus_b.dout;  n_b[i] = bus_b.done;
    end
  endtask

  function automatic logic [31:0] pack_da(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], d_a[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_db(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], d_b[i]};
    return v;
  endfunction

  function automatic int first_done(input bit sel_b, input int n);
    for (int i = 0; i < n; i++)
      if ((sel_b ? n_b[i] : n_a[i]) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_done_a(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (n_a[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    logic [31:0] vbits, bbits, nbits;
    int          det0;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    collect(3);
    checkOutput("reset_state", {27'd0, f_a[0], d_a[0]}, 32'h1);
    checkOutput("reset_flags", {29'd0, v_a[0], b_a[0], n_a[0]}, 32'h0);
    checkOutput("idle_hold", {28'd0, d_a[2], v_a[2], b_a[2], n_a[2]}, 32'h8);

    det0 = det_count;
    applyStimulus(8'h05, 4'd4, 4'd1);
    collect(6);
    vbits = '0; bbits = '0; nbits = '0;
    for (int i = 0; i < 6; i++) begin
      vbits = {vbits[30:0], v_a[i]};
      bbits = {bbits[30:0], b_a[i]};
      nbits = {nbits[30:0], n_a[i]};
    end
    checkOutput("single_bits", pack_da(4), 32'b0101);
    checkOutput("single_valid", vbits, 32'b111100);
    checkOutput("single_busy", bbits, 32'b111110);
    checkOutput("single_done", nbits, 32'b000010);
    checkOutput("detector_hits", 32'(det_count - det0), 32'd1);

    applyStimulus(8'h05, 4'd4, 4'd3);
    collect(16);
    checkOutput("rep3_gap_bits", pack_da(14), 32'b01011010110101);
    checkOutput("rep3_gap_done", 32'(first_done(1'b0, 16)), 32'd14);
    checkOutput("rep3_fidx_steps", {20'd0, f_a[4], f_a[9], f_a[14]}, 32'h123);
    checkOutput("rep3_nogap_bits", pack_db(12), 32'b010101010101);
    checkOutput("rep3_nogap_done", 32'(first_done(1'b1, 16)), 32'd12);

    applyStimulus(8'h04, 4'd0, 4'd1);
    collect(4);
    checkOutput("len0_bit", {30'd0, d_a[0], v_a[0]}, 32'b01);
    checkOutput("len0_done", 32'(first_done(1'b0, 4)), 32'd1);

    applyStimulus(8'h96, 4'd12, 4'd1);
    collect(10);
    checkOutput("len12_bits", pack_da(8), 32'h96);
    checkOutput("len12_done", 32'(first_done(1'b0, 10)), 32'd8);

    applyStimulus(8'h05, 4'd4, 4'd0);
    collect(8);
    checkOutput("rep0_done", 32'(first_done(1'b0, 8)), 32'd4);
    checkOutput("rep0_one_frame", 32'(count_done_a(8)), 32'd1);

    applyStimulus(8'h05, 4'd4, 4'd1);
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 8'hFF, 4'd8, 4'd2);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'hFF, 4'd8, 4'd2);
    collect(6);
    checkOutput("restart_ignored_bits", pack_da(2), 32'b01);
    checkOutput("restart_ignored_done", 32'(count_done_a(6)), 32'd1);
    checkOutput("restart_ignored_when", 32'(first_done(1'b0, 6)), 32'd2);

    applyStimulus(8'h05, 4'd4, 4'd1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 8'h05, 4'd4, 4'd1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'h05, 4'd4, 4'd1);
    collect(10);
    checkOutput("abort_idle", {28'd0, d_a[0], v_a[0], b_a[0], f_a[0] == 4'd0}, 32'b1001);
    checkOutput("abort_no_done", 32'(count_done_a(10)), 32'd0);

    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 8'h05, 4'd4, 4'd1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'h05, 4'd4, 4'd1);
    collect(3);
    checkOutput("start_abort_no_load", {29'd0, b_a[0], b_a[1], v_a[0]}, 32'd0);

    applyStimulus(8'h05, 4'd4, 4'd3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    collect(1);
    checkOutput("reset_in_gap", {24'd0, f_a[0], n_a[0], b_a[0], v_a[0], d_a[0]}, 32'h01);

    applyStimulus(8'h05, 4'd4, 4'd1);
    collect(6);
    checkOutput("after_reset_bits", pack_da(4), 32'b0101);
    checkOutput("after_reset_fidx", {24'd0, f_a[0], f_a[4]}, 32'h01);
    checkOutput("after_reset_done", 32'(first_done(1'b0, 6)), 32'd4);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/lly_seq_tx.md
Name: lly_seq_tx

Overview:
- Serial pattern transmitter that drives the single-bit `ina` stream consumed by the team's 0101 sequence detector. It also serves as a general stimulus source for serial FSM labs.
- Loads an up-to-W-bit pattern on a start strobe and shifts it out MSB-first, one bit per clock.
- Optionally repeats the frame N times, with an idle-level gap between frames.
- Reports completion with busy, bit_valid and a done pulse.

Parameters:
- W, 8, maximum pattern width in bits.
- LEN_W, 4, width of the len input; must be able to hold W.
- REP_W, 4, width of the repeat-count input.
- GAP_CYC, 1, idle cycles inserted between repeated frames; 0 means back-to-back frames.
- IDLE_LVL, 1'b1, dout level when not shifting. A 1 keeps the detector parked in its initial state.

Ports:
- Clk  in  1  system clock, all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel the transmission in progress.
- pattern  in  W  bits to send; bit len-1 goes first.
- len  in  LEN_W  frame length in bits.
- rep  in  REP_W  number of frames to send.
- dout  out  1  serial data (registered).
- bit_valid  out  1  high on cycles where dout carries a pattern bit.
- busy  out  1  high from the first data cycle through the done cycle.
- done  out  1  one-cycle pulse after the last bit of the last frame.
- frame_idx  out  REP_W  number of frames fully sent so far in this transmission.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
  - On a Reset edge: state=IDLE, dout=IDLE_LVL, bit_valid=0, busy=0, done=0, frame_idx=0, all internal registers cleared.
  - Reset mid-frame aborts immediately and produces no done pulse.
- Priority at every edge: Reset > abort > start.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge k latches pattern into pat_q.
  - len is clamped: 0→1, >W→W, result into len_q. rep is clamped: 0→1, into rep_q.
  - Sets idx=len_q-1 and frame_idx=0, and goes to SHIFT.
  - In that same edge: dout<=pattern[len_q-1], bit_valid<=1, busy<=1. The first bit is therefore visible in cycle k+1.
- SHIFT:
  - Each edge decrements idx and drives dout<=pat_q[idx].
  - When the bit just output had idx==0, increment frame_idx.
  - If frame_idx+1 < rep_q:
    - GAP_CYC>0: go to GAP.
    - GAP_CYC=0: reload idx=len_q-1 and continue in SHIFT with no idle cycle.
  - Otherwise go to DONE.
- GAP:
  - dout=IDLE_LVL, bit_valid=0, busy=1, for exactly GAP_CYC cycles (gap counter).
  - Then go to SHIFT with idx=len_q-1; the first bit appears on the cycle after the gap.
- DONE:
  - One cycle with done=1, busy=1, dout=IDLE_LVL, bit_valid=0.
  - Next edge returns to IDLE with busy=0 and done=0.
- Timing summary: a transmission occupies rep_q*len_q + (rep_q-1)*GAP_CYC + 1 cycles of busy.
- start while busy (SHIFT, GAP or DONE) is ignored. Changes on pattern, len and rep after the load have no effect on the current transmission.
- abort in SHIFT or GAP:
  - Next edge: IDLE, dout=IDLE_LVL, bit_valid=0, busy=0, done=0; frame_idx holds its value.
  - abort in IDLE or DONE is ignored; DONE completes normally.
- Simultaneous start and abort in IDLE: abort wins and no load occurs.
- Width rules: idx is LEN_W bits, the decrement never underflows (it is guarded by the idx==0 check), and the frame_idx compare is unsigned.

Decomposition:
- Shared package lly_seq_pkg holds:
  - the state encoding constants S_IDLE=2'b00, S_SHIFT=2'b01, S_GAP=2'b10, S_DONE=2'b11;
  - IDLE_LVL default;
  - a clamp function for len and rep.
- One natural sub-module, lly_tx_shreg: a loadable W-bit MSB-first shift register with a bit counter and last-bit flag. The top level keeps the FSM, the repeat/gap counters and the outputs.

Test Plan:
- Reset held 2 cycles, then released → dout=1, busy=0, bit_valid=0, done=0, frame_idx=0; stays idle with start=0.
- pattern=8'h05, len=4, rep=1, start pulsed at edge k:
  - dout is 0,1,0,1 in cycles k+1..k+4, with bit_valid=1 on those cycles;
  - done=1 only in k+5; busy=1 over k+1..k+5;
  - dout fed to the 0101 detector's ina → detector output asserts exactly once.
- pattern=8'h05, len=4, rep=3, GAP_CYC=1:
  - dout is 0101 1 0101 1 0101; frame_idx steps 1,2,3;
  - done in the 15th cycle after start.
  - Rerun with GAP_CYC=0 → 12 contiguous bits, done in the 13th cycle.
- Clamping:
  - len=0 → single bit, pattern[0];
  - len=12 with W=8 → 8 bits starting at pattern[7];
  - rep=0 → one frame.
- start re-asserted at bit 2 of a len=4 frame → ignored, frame completes unchanged. abort at bit 2 → next cycle dout=1, busy=0, bit_valid=0, and no done pulse ever.
- Reset asserted in GAP with rep=3 → next cycle all outputs at reset values. A fresh start then transmits normally from frame 0.
